gcd_controller: RTL and testbench
=================================

# gcd_controller

Control FSM paired with `GCD_datapath`: accepts two 16-bit operands over a valid/ready handshake, drives the datapath load and mux selects, and iterates the subtract loop from the datapath's `gt`/`lt`/`eq` flags. It signals completion, or a bounded-iteration error, and holds that status until acknowledged. The GCD result stays in datapath register A; the top level taps it when `done` is high.

## Interface
- `MAX_ITER`, 65535: subtract steps allowed before abort; 1..65535.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand word on datapath `data_in` is valid.
- `in_ready`  out  1  controller accepts an operand word this cycle.
- `gt`, `lt`, `eq`  in  1 each  datapath compare flags (A>B, A<B, A==B).
- `ldA`, `ldB`  out  1 each  datapath register load enables.
- `sel1`, `sel2`, `sel_in`  out  1 each  datapath mux selects (1 selects first mux input).
- `ack`  in  1  consumer acknowledges `done`/`err`.
- `done`  out  1  GCD complete; datapath register A holds the result.
- `err`  out  1  iteration limit hit; result invalid.
- `iter_count`  out  16  subtract steps performed in the current/last run.

## Operation
- States: IDLE, GET_B, CALC, DONE, ERR. Encoding is free.
- IDLE: `in_ready`=1. On `in_valid`: `sel_in`=1, `ldA`=1, clear `iter_count`, go to GET_B.
- GET_B: `in_ready`=1. On `in_valid`: `sel_in`=1, `ldB`=1, go to CALC. Otherwise wait indefinitely.
- CALC: `in_ready`=0, `sel_in`=0. Flags are evaluated in priority order `eq`, then `iter_count`==`MAX_ITER`, then `gt`/`lt`:
  - `eq`: go to DONE.
  - `iter_count`==`MAX_ITER` and not `eq`: go to ERR; no load.
  - `gt`: `sel1`=1, `sel2`=0, `ldA`=1 (A <= A-B); `iter_count`+1.
  - `lt`: `sel1`=0, `sel2`=1, `ldB`=1 (B <= B-A); `iter_count`+1.
- DONE: `done`=1. On `ack`, go to IDLE.
- ERR: `err`=1. On `ack`, go to IDLE.
- `ldA`/`ldB` are Mealy outputs (state plus `in_valid` or flags). `done`/`err`/`in_ready` are Moore outputs.
- Outside the cases above: `ldA`=`ldB`=0; `sel1`=`sel2`=`sel_in`=0, except `sel_in`=1 throughout IDLE and GET_B.
- `iter_count` is a 16-bit register. It saturates at `MAX_ITER`, never wraps, and is held in DONE/ERR until the next operand-A accept.
- A zero operand with a nonzero partner never converges and ends in ERR. Both operands zero gives `eq` immediately: DONE, result 0.
- `ack` outside DONE/ERR is ignored. `in_valid` during CALC/DONE/ERR is not accepted (`in_ready`=0).
- `ack` and `in_valid` together in DONE: return to IDLE only. The operand is accepted in the following cycle if `in_valid` is still high.

## Timing
- Reset (asynchronous, effective immediately): state IDLE, `iter_count`=0, `done`=`err`=0, `ldA`=`ldB`=0, `sel1`=`sel2`=0. While `rst` is high, `ldA`/`ldB` are forced to 0 regardless of `in_valid`. After release, `in_ready`=1 and `sel_in`=1.
- Reset mid-CALC or mid-DONE: loop abandoned, no further loads. Datapath register contents are don't-care.
- Operand A accepted at edge k0. Operand B accepted earliest at edge k0+1.
- B accepted at edge k: CALC occupies cycles k+1 .. k+N+1 for N subtract steps. `done` rises at cycle k+N+2.
- Error run: ERR entered the cycle after the CALC cycle in which `iter_count`==`MAX_ITER`.
- `done`/`err` drop the cycle after `ack` is sampled high. `in_ready` rises in that same cycle.
- Throughput: one subtract per clock. No bubble cycles inside CALC.

## Test plan
- A=12, B=8 -> two subtracts (A=4, then B=4). `done` at k+4, `iter_count`=2, register A=4, `err`=0.
- A=21, B=6 -> `gt` x3, then `lt` x1. `done` at k+6, `iter_count`=4, result 3.
- A=9, B=9 and A=0, B=0 -> `done` at k+2, `iter_count`=0; results 9 and 0.
- MAX_ITER=8, A=7, B=0 -> eight `ldA` pulses, then `err`=1, `done`=0, `iter_count`=8. `ack` returns to IDLE with `in_ready`=1.
- `in_valid` held high through the whole run, including gaps between operand A and B -> exactly two accepts per run. `ack` and `in_valid` together in DONE -> next A accepted one cycle later. `in_valid`=0 in GET_B for 5 cycles -> state holds, no loads.
- `rst` pulsed mid-CALC (A=21, B=6, after 2 steps) -> `ldA`/`ldB` drop immediately, outputs at reset values. The next run A=12, B=8 completes normally.

Source files
------------

// File: rtl/gcd_controller.sv
// Control FSM for a subtractive GCD datapath.
// Accepts operand A, then operand B, over a valid/ready handshake. It then
// steers the datapath through A<=A-B / B<=B-A steps until the compare flags
// report equality (done) or the step budget runs out (err). The status is held
// until ack; the result remains in datapath register A.
module gcd_controller #(
   parameter int unsigned MAX_ITER = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        gt,
   input  logic        lt,
   input  logic        eq,
   output logic        ldA,
   output logic        ldB,
   output logic        sel1,
   output logic        sel2,
   output logic        sel_in,
   input  logic        ack,
   output logic        done,
   output logic        err,
   output logic [15:0] iter_count
);

   typedef enum logic [2:0] {
      StIdle,
      StGetB,
      StCalc,
      StDone,
      StErr
   } state_t;

   localparam logic [15:0] MaxIter = 16'(MAX_ITER);

   state_t      state_q, state_d;
   logic [15:0] iter_q, iter_d;

   // State and step-counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         iter_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
      end
   end

   // Next-state logic and datapath control; loads are Mealy, status is Moore.
   always_comb begin
      state_d  = state_q;
      iter_d   = iter_q;
      in_ready = 1'b0;
      ldA      = 1'b0;
      ldB      = 1'b0;
      sel1     = 1'b0;
      sel2     = 1'b0;
      sel_in   = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            sel_in   = 1'b1;
            if (in_valid) begin
               ldA     = 1'b1;
               iter_d  = 16'd0;
               state_d = StGetB;
            end
         end
         StGetB: begin
            in_ready = 1'b1;
            sel_in   = 1'b1;
            if (in_valid) begin
               ldB     = 1'b1;
               state_d = StCalc;
            end
         end
         StCalc: begin
            // Equality wins over the budget check, so a run that converges on
            // exactly the last allowed step still completes.
            if (eq) begin
               state_d = StDone;
            end else if (iter_q == MaxIter) begin
               state_d = StErr;
            end else if (gt) begin
               sel1 = 1'b1;
               ldA  = 1'b1;
               if (iter_q < MaxIter) iter_d = iter_q + 16'd1;
            end else if (lt) begin
               sel2 = 1'b1;
               ldB  = 1'b1;
               if (iter_q < MaxIter) iter_d = iter_q + 16'd1;
            end
         end
         StDone: begin
            done = 1'b1;
            if (ack) state_d = StIdle;
         end
         StErr: begin
            err = 1'b1;
            if (ack) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // Reset forces the state to IDLE, but the Mealy loads would otherwise
      // follow in_valid while reset is still asserted.
      if (rst) begin
         ldA = 1'b0;
         ldB = 1'b0;
      end
   end

   assign iter_count = iter_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: a small behavioural GCD datapath closes the loop,
// and each run is compared against an arithmetic model of the subtractive GCD.
module tb_gcd_controller;

   localparam int unsigned MAX = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        gt, lt, eq;
   logic        ldA, ldB, sel1, sel2, sel_in;
   logic        ack;
   logic        done, err;
   logic [15:0] iter_count;
   logic [15:0] data_in;
   logic [15:0] reg_a = 16'd0;
   logic [15:0] reg_b = 16'd0;
   logic [15:0] opx, opy, dp_in;

   int n_cmp = 0;
   int n_bad = 0;

   gcd_controller #(.MAX_ITER(MAX)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .gt         (gt),
      .lt         (lt),
      .eq         (eq),
      .ldA        (ldA),
      .ldB        (ldB),
      .sel1       (sel1),
      .sel2       (sel2),
      .sel_in     (sel_in),
      .ack        (ack),
      .done       (done),
      .err        (err),
      .iter_count (iter_count)
   );

   always #5 clk = ~clk;

   // Datapath: subtractor operands muxed by sel1/sel2, load mux by sel_in.
   assign opx   = sel1 ? reg_a : reg_b;
   assign opy   = sel2 ? reg_a : reg_b;
   assign dp_in = sel_in ? data_in : 16'(opx - opy);
   assign gt    = reg_a > reg_b;
   assign lt    = reg_a < reg_b;
   assign eq    = reg_a == reg_b;

   always @(posedge clk) begin
      if (ldA) reg_a <= dp_in;
      if (ldB) reg_b <= dp_in;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Subtractive GCD with a step budget: result, steps, A-steps, B-steps, error.
   function automatic void model(input int a, input int b, output int res, output int n,
                                 output int na, output int nb, output bit e);
      n  = 0;
      na = 0;
      nb = 0;
      while (a != b && n < MAX) begin
         if (a > b) begin
            a -= b;
            na++;
         end else begin
            b -= a;
            nb++;
         end
         n++;
      end
      res = a;
      e   = (a != b);
   endfunction

   // One full transaction, starting at a negedge with the controller in IDLE.
   task automatic run(input int a, input int b, input int gap, input bit hold,
                      input bit ack_valid);
      int res, n, na, nb, cnt, ca, cb;
      bit e;
      model(a, b, res, n, na, nb, e);
      chk("idle_ready", in_ready, 1);
      chk("idle_sel_in", sel_in, 1);
      data_in  = 16'(a);
      in_valid = 1'b1;
      #1;
      chk("accept_a_ldA", ldA, 1);
      chk("accept_a_ldB", ldB, 0);
      @(negedge clk);
      chk("getb_ready", in_ready, 1);
      chk("iter_cleared", iter_count, 0);
      if (!hold) begin
         for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            #1;
            chk("gap_ldA", ldA, 0);
            chk("gap_ldB", ldB, 0);
            chk("gap_ready", in_ready, 1);
            @(negedge clk);
         end
      end
      data_in  = 16'(b);
      in_valid = 1'b1;
      #1;
      chk("accept_b_ldB", ldB, 1);
      chk("accept_b_ldA", ldA, 0);
      @(negedge clk);
      in_valid = hold;
      data_in  = 16'hffff;
      cnt = 1;
      ca  = 0;
      cb  = 0;
      while (!(done || err) && cnt < 200) begin
         chk("calc_ready", in_ready, 0);
         ca += int'(ldA);
         cb += int'(ldB);
         @(negedge clk);
         cnt++;
      end
      chk("status_latency", cnt, n + 2);
      chk("ldA_pulses", ca, na);
      chk("ldB_pulses", cb, nb);
      chk("done_flag", done, !e);
      chk("err_flag", err, e);
      chk("iter_count", iter_count, n);
      if (!e) chk("result_a", reg_a, res);
      chk("status_ready", in_ready, 0);
      chk("status_ldA", ldA, 0);
      @(negedge clk);
      chk("done_held", done, !e);
      chk("err_held", err, e);
      chk("iter_held", iter_count, n);
      ack = 1'b1;
      if (ack_valid) in_valid = 1'b1;
      #1;
      chk("ack_no_accept", ldA, 0);
      @(negedge clk);
      ack = 1'b0;
      chk("ack_done_drop", done, 0);
      chk("ack_err_drop", err, 0);
      chk("ack_ready", in_ready, 1);
      if (ack_valid || hold) chk("accept_after_ack", ldA, 1);
      else in_valid = 1'b0;
   endtask

   initial begin
      int cnt;
      rst      = 1'b1;
      in_valid = 1'b0;
      ack      = 1'b0;
      data_in  = 16'd0;
      @(negedge clk);
      chk("rst_iter", iter_count, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_ldA", ldA, 0);
      chk("rst_sel1", sel1, 0);
      in_valid = 1'b1;
      #1;
      chk("rst_forces_ldA", ldA, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_sel_in", sel_in, 1);
      @(negedge clk);

      // Directed cases.
      run(12, 8, 0, 1'b0, 1'b0);
      run(21, 6, 1, 1'b0, 1'b0);
      run(9, 9, 0, 1'b0, 1'b0);
      run(0, 0, 0, 1'b0, 1'b0);
      run(7, 0, 0, 1'b0, 1'b0);
      run(9, 1, 5, 1'b0, 1'b0);
      run(10, 1, 0, 1'b0, 1'b1);
      run(15, 10, 0, 1'b1, 1'b0);
      run(12, 8, 0, 1'b0, 1'b0);

      // Randomized runs.
      for (int r = 0; r < 16; r++) begin
         run(int'($urandom_range(0, 14)), int'($urandom_range(0, 14)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      in_valid = 1'b0;
      @(negedge clk);

      // Reset mid-CALC for A=21, B=6 after two steps.
      data_in  = 16'd21;
      in_valid = 1'b1;
      @(negedge clk);
      data_in = 16'd6;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midcalc_iter", iter_count, 2);
      chk("midcalc_ldA", ldA, 1);
      rst      = 1'b1;
      in_valid = 1'b1;
      #1;
      chk("midrst_ldA", ldA, 0);
      chk("midrst_ldB", ldB, 0);
      chk("midrst_iter", iter_count, 0);
      chk("midrst_done", done, 0);
      chk("midrst_err", err, 0);
      chk("midrst_sel1", sel1, 0);
      chk("midrst_sel2", sel2, 0);
      @(negedge clk);
      chk("midrst_hold_ldA", ldA, 0);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("midrst_rel_ready", in_ready, 1);
      chk("midrst_rel_sel_in", sel_in, 1);
      cnt = 0;
      repeat (2) begin
         @(negedge clk);
         cnt += int'(ldA) + int'(ldB);
      end
      chk("midrst_no_loads", cnt, 0);
      run(12, 8, 0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
